// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, game_win result codes, default board
// length and round count, and the LFSR-to-dice mapping.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitRoll = 3'd1,
    StMove     = 3'd2,
    StCheck    = 3'd3,
    StDone     = 3'd4
  } state_t;

  // game_win encodings, shared with the match tracker
  localparam logic [1:0] WIN_DRAW = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned DEF_BOARD_LEN  = 20;
  localparam int unsigned DEF_MAX_ROUNDS = 10;

  // Maps a raw LFSR state onto a die face 1..6
  function automatic logic [2:0] dice_map(input logic [7:0] v);
    logic [7:0] rem;
    rem = v % 8'd6;
    return rem[2:0] + 3'd1;
  endfunction

endpackage

// File: rtl/game_play_fsm_if.sv
// Control and status bundle of the game-play FSM. The master side issues game commands
// and roll presses; the slave side (the FSM) reports board state and results.
interface game_play_fsm_if;

  logic       game_start;
  logic       restart;
  logic       btn_roll;
  logic       game_end;
  logic [1:0] game_win;
  logic       turn;
  logic [2:0] dice_val;
  logic [4:0] pos_p1;
  logic [4:0] pos_p2;
  logic [3:0] round_cnt;
  logic       busy;

  modport master (
    output game_start, restart, btn_roll,
    input  game_end, game_win, turn, dice_val, pos_p1, pos_p2, round_cnt, busy
  );

  modport slave (
    input  game_start, restart, btn_roll,
    output game_end, game_win, turn, dice_val, pos_p1, pos_p2, round_cnt, busy
  );

endinterface

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with a combinational
// mapping of its current state onto a die face 1..6.
module dice_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] dice
);

  // An all-zero seed would lock the register up, so it is replaced by a legal value
  localparam logic [7:0] SeedSafe = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  // Feedback from taps 8,6,5,4 (bits 7,5,4,3); the face follows the current state
  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = {lfsr_q[6:0], feedback};
    dice     = dice_map(lfsr_q);
  end

  // Advance every cycle, whatever the game is doing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SeedSafe;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/game_play_fsm.sv
// Two-player race game: players alternate dice rolls, tokens advance one cell per step
// period, and the game ends on reaching the goal (with a last-chance turn for P2) or
// after the final round, by comparing positions.
module game_play_fsm
  import game_pkg::*;
#(
  parameter int unsigned BOARD_LEN   = DEF_BOARD_LEN,
  parameter int unsigned MAX_ROUNDS  = DEF_MAX_ROUNDS,
  parameter int unsigned STEP_CYCLES = 10_000_000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  game_play_fsm_if.slave  bus
);

  localparam int unsigned StepW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
  localparam logic [4:0]  BoardLen  = 5'(BOARD_LEN);
  localparam logic [3:0]  MaxRounds = 4'(MAX_ROUNDS);

  state_t           state_q, state_d;
  logic             turn_q, turn_d;
  logic [2:0]       dice_val_q, dice_val_d;
  logic [4:0]       pos_p1_q, pos_p1_d;
  logic [4:0]       pos_p2_q, pos_p2_d;
  logic [3:0]       round_q, round_d;
  logic [2:0]       remain_q, remain_d;
  logic [StepW-1:0] step_q, step_d;
  logic             game_end_q, game_end_d;
  logic [1:0]       game_win_q, game_win_d;

  logic [2:0]       roll;
  logic [4:0]       active_pos;

  dice_lfsr #(
    .SEED (LFSR_SEED)
  ) u_dice (
    .clk   (clk),
    .rst_n (rst_n),
    .dice  (roll)
  );

  assign active_pos = turn_q ? pos_p2_q : pos_p1_q;

  // Next-state logic; restart overrides every other input in every state
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    dice_val_d = dice_val_q;
    pos_p1_d   = pos_p1_q;
    pos_p2_d   = pos_p2_q;
    round_d    = round_q;
    remain_d   = remain_q;
    step_d     = step_q;
    game_end_d = 1'b0;
    game_win_d = game_win_q;

    if (bus.restart) begin
      state_d    = StIdle;
      turn_d     = 1'b0;
      dice_val_d = '0;
      pos_p1_d   = '0;
      pos_p2_d   = '0;
      round_d    = '0;
      remain_d   = '0;
      step_d     = '0;
      game_win_d = WIN_DRAW;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.game_start) begin
            state_d    = StWaitRoll;
            turn_d     = 1'b0;
            dice_val_d = '0;
            pos_p1_d   = '0;
            pos_p2_d   = '0;
            round_d    = 4'd1;
            remain_d   = '0;
            step_d     = '0;
            game_win_d = WIN_DRAW;
          end
        end

        StWaitRoll: begin
          if (bus.btn_roll) begin
            dice_val_d = roll;
            remain_d   = roll;
            step_d     = '0;
            state_d    = StMove;
          end
        end

        StMove: begin
          if (active_pos >= BoardLen) begin
            // Already on the goal: nothing left to move
            state_d = StCheck;
          end else if (step_q == StepLast) begin
            step_d   = '0;
            remain_d = remain_q - 3'd1;
            if (turn_q) begin
              pos_p2_d = pos_p2_q + 5'd1;
            end else begin
              pos_p1_d = pos_p1_q + 5'd1;
            end
            // Landing on the goal discards whatever is left of the roll
            if (remain_q == 3'd1 || (active_pos + 5'd1) == BoardLen) begin
              state_d = StCheck;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end

        StCheck: begin
          if (turn_q && pos_p2_q == BoardLen) begin
            game_win_d = (pos_p1_q == BoardLen) ? WIN_DRAW : WIN_P2;
            game_end_d = 1'b1;
            state_d    = StDone;
          end else if (turn_q && pos_p1_q == BoardLen) begin
            // P2 used its last-chance turn and fell short
            game_win_d = WIN_P1;
            game_end_d = 1'b1;
            state_d    = StDone;
          end else if (!turn_q && pos_p1_q == BoardLen) begin
            // P1 finished first; P2 still gets one last-chance turn
            turn_d  = 1'b1;
            state_d = StWaitRoll;
          end else if (turn_q && round_q == MaxRounds) begin
            if (pos_p1_q > pos_p2_q) begin
              game_win_d = WIN_P1;
            end else if (pos_p2_q > pos_p1_q) begin
              game_win_d = WIN_P2;
            end else begin
              game_win_d = WIN_DRAW;
            end
            game_end_d = 1'b1;
            state_d    = StDone;
          end else begin
            turn_d  = ~turn_q;
            if (turn_q) begin
              round_d = round_q + 4'd1;
            end
            state_d = StWaitRoll;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      turn_q     <= 1'b0;
      dice_val_q <= '0;
      pos_p1_q   <= '0;
      pos_p2_q   <= '0;
      round_q    <= '0;
      remain_q   <= '0;
      step_q     <= '0;
      game_end_q <= 1'b0;
      game_win_q <= WIN_DRAW;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      dice_val_q <= dice_val_d;
      pos_p1_q   <= pos_p1_d;
      pos_p2_q   <= pos_p2_d;
      round_q    <= round_d;
      remain_q   <= remain_d;
      step_q     <= step_d;
      game_end_q <= game_end_d;
      game_win_q <= game_win_d;
    end
  end

  assign bus.game_end  = game_end_q;
  assign bus.game_win  = game_win_q;
  assign bus.turn      = turn_q;
  assign bus.dice_val  = dice_val_q;
  assign bus.pos_p1    = pos_p1_q;
  assign bus.pos_p2    = pos_p2_q;
  assign bus.round_cnt = round_q;
  assign bus.busy      = (state_q == StMove) || (state_q == StCheck);

endmodule

// File: tb/tb_game_play_fsm.sv
// Directed bench for game_play_fsm on an 8-cell board, 3 rounds, 4-cycle steps.
// Rolls are timed against a reference LFSR so each turn gets a chosen die face.
module tb_game_play_fsm;

  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  game_play_fsm_if bus ();

  game_play_fsm #(
    .BOARD_LEN   (8),
    .MAX_ROUNDS  (3),
    .STEP_CYCLES (4),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int exp_p1 = 0;
  int exp_p2 = 0;
  bit exp_turn = 1'b0;

  // Reference dice LFSR: x^8+x^6+x^5+x^4+1, feedback = parity of bits 7,5,4,3
  logic [7:0] ref_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 8'hA5;
    else        ref_lfsr <= {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_game_end"}, bus.game_end, 0);
    check({tag, "_game_win"}, bus.game_win, 0);
    check({tag, "_turn"}, bus.turn, 0);
    check({tag, "_dice"}, bus.dice_val, 0);
    check({tag, "_pos_p1"}, bus.pos_p1, 0);
    check({tag, "_pos_p2"}, bus.pos_p2, 0);
    check({tag, "_round"}, bus.round_cnt, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic start_game();
    bus.game_start = 1'b1;
    @(negedge clk);
    bus.game_start = 1'b0;
    exp_p1 = 0;
    exp_p2 = 0;
    exp_turn = 1'b0;
    check("start_round", bus.round_cnt, 1);
    check("start_turn", bus.turn, 0);
    check("start_busy", bus.busy, 0);
    check("start_win", bus.game_win, 0);
    check("start_pos_p1", bus.pos_p1, 0);
    check("start_pos_p2", bus.pos_p2, 0);
  endtask

  // Wait until the reference LFSR shows the wanted face, then press roll for one cycle
  task automatic roll(input int want);
    int n;
    n = 0;
    while ((int'(ref_lfsr % 8'd6) + 1) != want && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("roll_wait_bound", (n < 300), 1);
    bus.btn_roll = 1'b1;
    @(negedge clk);
    bus.btn_roll = 1'b0;
  endtask

  // One turn of the expected mover; returns just after the CHECK decision
  task automatic take_turn(input int want, input int exp_pos, input int exp_turn_n,
                           input int exp_round, input int exp_end, input int exp_win,
                           input bit poke);
    int prev;
    int s;
    prev = exp_turn ? exp_p2 : exp_p1;
    s = exp_pos - prev;
    roll(want);
    check("dice_val", bus.dice_val, want);
    check("busy_in_move", bus.busy, 1);
    for (int k = 0; k < 4 * s + 1; k++) begin
      @(negedge clk);
      bus.btn_roll = 1'b0;
      bus.game_start = 1'b0;
      if (k == 2) check("pos_before_step", exp_turn ? bus.pos_p2 : bus.pos_p1, prev);
      if (k == 3) check("pos_first_step", exp_turn ? bus.pos_p2 : bus.pos_p1, prev + 1);
      if (poke && k == 2) begin
        bus.btn_roll = 1'b1;
        bus.game_start = 1'b1;
      end
    end
    if (exp_turn) exp_p2 = exp_pos;
    else          exp_p1 = exp_pos;
    exp_turn = exp_turn_n[0];
    check("pos_p1", bus.pos_p1, exp_p1);
    check("pos_p2", bus.pos_p2, exp_p2);
    check("turn", bus.turn, exp_turn_n);
    check("round_cnt", bus.round_cnt, exp_round);
    check("game_end", bus.game_end, exp_end);
    check("game_win", bus.game_win, exp_win);
    check("busy_after", bus.busy, 0);
    if (exp_end != 0) begin
      @(negedge clk);
      check("game_end_single", bus.game_end, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.game_start = 1'b0;
    bus.restart = 1'b0;
    bus.btn_roll = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("idle");

    // Game A: P1 reaches goal, P2 falls short on last-chance turn -> P1 wins
    start_game();
    take_turn(4, 4, 1, 1, 0, 0, 1'b0);
    take_turn(1, 1, 0, 2, 0, 0, 1'b0);
    take_turn(4, 8, 1, 2, 0, 0, 1'b0);
    take_turn(2, 3, 1, 2, 1, 1, 1'b0);
    bus.btn_roll = 1'b1;
    @(negedge clk);
    bus.btn_roll = 1'b0;
    repeat (8) @(negedge clk);
    check("done_roll_pos_p1", bus.pos_p1, 8);
    check("done_roll_pos_p2", bus.pos_p2, 3);
    check("done_roll_dice", bus.dice_val, 2);
    check("done_roll_busy", bus.busy, 0);
    check("done_hold_win", bus.game_win, 1);

    // Game B: a 6 from cell 5 saturates at 8, then both on goal -> draw
    start_game();
    take_turn(5, 5, 1, 1, 0, 0, 1'b0);
    take_turn(5, 5, 0, 2, 0, 0, 1'b0);
    take_turn(6, 8, 1, 2, 0, 0, 1'b0);
    take_turn(3, 8, 1, 2, 1, 0, 1'b0);

    // Game C: rounds run out at 5 vs 6 -> P2 wins
    start_game();
    take_turn(2, 2, 1, 1, 0, 0, 1'b0);
    take_turn(2, 2, 0, 2, 0, 0, 1'b0);
    take_turn(2, 4, 1, 2, 0, 0, 1'b0);
    take_turn(2, 4, 0, 3, 0, 0, 1'b0);
    take_turn(1, 5, 1, 3, 0, 0, 1'b0);
    take_turn(2, 6, 1, 3, 1, 2, 1'b0);

    // Game D: stray roll/start inputs ignored; rounds run out at 6 vs 6 -> draw
    start_game();
    take_turn(3, 3, 1, 1, 0, 0, 1'b1);
    bus.game_start = 1'b1;
    @(negedge clk);
    bus.game_start = 1'b0;
    @(negedge clk);
    check("wait_start_round", bus.round_cnt, 1);
    check("wait_start_turn", bus.turn, 1);
    check("wait_start_pos_p1", bus.pos_p1, 3);
    take_turn(3, 3, 0, 2, 0, 0, 1'b0);
    take_turn(2, 5, 1, 2, 0, 0, 1'b0);
    take_turn(2, 5, 0, 3, 0, 0, 1'b0);
    take_turn(1, 6, 1, 3, 0, 0, 1'b0);
    take_turn(1, 6, 1, 3, 1, 0, 1'b0);

    // Restart together with game_start mid-move
    start_game();
    roll(3);
    repeat (5) @(negedge clk);
    check("mid_move_pos_p1", bus.pos_p1, 1);
    bus.restart = 1'b1;
    bus.game_start = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    bus.game_start = 1'b0;
    check_idle("restart_move");

    // Restart together with a roll press in WAIT_ROLL
    start_game();
    bus.restart = 1'b1;
    bus.btn_roll = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    bus.btn_roll = 1'b0;
    check_idle("restart_roll");

    // Asynchronous reset mid-move
    start_game();
    roll(2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_play_fsm.md
GAME_PLAY_FSM -- requirements
Module: game_play_fsm

Interface
REQ-001 Parameter BOARD_LEN, default 20: goal cell index; positions range 0..BOARD_LEN.
REQ-002 Parameter MAX_ROUNDS, default 10: rounds per game; one round is a P1 turn followed by a P2 turn.
REQ-003 Parameter STEP_CYCLES, default 10_000_000: cycles per one-cell move step, 100 ms at 100 MHz.
REQ-004 Parameter LFSR_SEED, default 8'hA5: dice LFSR reset value; must be nonzero.
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 game_start  in  1  single-cycle pulse; starts one game. Driven by match start or the match tracker's next_match tick.
REQ-008 restart  in  1  single-cycle pulse; abort to IDLE.
REQ-009 btn_roll  in  1  debounced single-cycle pulse; the current player rolls the dice.
REQ-010 game_end  out  1  single-cycle pulse; game finished.
REQ-011 game_win  out  2  00 draw, 01 P1 wins, 10 P2 wins; held until the next game_start or restart.
REQ-012 turn  out  1  0 = P1 to move, 1 = P2 to move.
REQ-013 dice_val  out  3  last rolled value 1..6; 0 = no roll yet.
REQ-014 pos_p1, pos_p2  out  5 each  board positions.
REQ-015 round_cnt  out  4  current round, 1..MAX_ROUNDS; 0 in IDLE.
REQ-016 busy  out  1  high in every state except IDLE, WAIT_ROLL and DONE.

Function
REQ-017 States: IDLE, WAIT_ROLL, MOVE, CHECK, DONE.
REQ-018 IDLE: outputs hold their reset values. game_start -> WAIT_ROLL with turn=0, round_cnt=1, positions=0, dice_val=0.
REQ-019 WAIT_ROLL: btn_roll latches dice_val = (lfsr mod 6)+1, loads remaining steps = dice_val, then -> MOVE on the next cycle.
REQ-020 btn_roll is ignored in every state except WAIT_ROLL.
REQ-021 MOVE: every STEP_CYCLES cycles, the active player's position +1 and remaining -1. When remaining reaches 0, or position reaches BOARD_LEN, -> CHECK.
REQ-022 Positions saturate at BOARD_LEN; any excess roll is discarded.
REQ-023 CHECK, in one cycle, applies these rules in priority order:
  (a) P2 just moved and pos_p2==BOARD_LEN: win = draw if pos_p1==BOARD_LEN, else P2.
  (b) P2 just moved and pos_p1==BOARD_LEN: win = P1 (P2 had a last-chance turn).
  (c) P1 just moved and pos_p1==BOARD_LEN: turn=1 -> WAIT_ROLL (last-chance turn).
  (d) P2 just moved and round_cnt==MAX_ROUNDS: higher position wins; equal = draw.
  (e) Otherwise toggle turn; on P2->P1, round_cnt +1; -> WAIT_ROLL.
REQ-024 Cases (a), (b) and (d) -> DONE, assert game_end for exactly one cycle and update game_win in that same cycle.
REQ-025 DONE: positions, dice_val and game_win hold. game_start -> WAIT_ROLL with a fresh game, where game_win resets to 00.
REQ-026 restart in any state -> IDLE next cycle and clears all outputs. restart has priority over a simultaneous game_start or btn_roll.
REQ-027 game_start while busy or in WAIT_ROLL is ignored.
REQ-028 Dice LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances every cycle, including in IDLE. It never reaches the all-zero state.
REQ-029 The step counter is width $clog2(STEP_CYCLES) and clears on every MOVE entry.

Reset
REQ-030 rst_n low immediately forces state IDLE, game_end=0, game_win=00, turn=0, dice_val=0, pos_p1=pos_p2=0, round_cnt=0, busy=0, lfsr=LFSR_SEED, and all counters to 0.
REQ-031 rst_n asserted mid-MOVE discards the partial move; no game_end pulse is produced.

Structure
REQ-032 A shared package, game_pkg, holds: the state_t enum; the game_win encodings WIN_DRAW/WIN_P1/WIN_P2, also used by the match tracker; and the default constants for board length and rounds.
REQ-033 One sub-module, dice_lfsr, contains the LFSR and the mod-6 mapping. It outputs a 3-bit value 1..6 every cycle; game_play_fsm latches that value.

Verification (BOARD_LEN=8, MAX_ROUNDS=3, STEP_CYCLES=4)
REQ-034 Reset then game_start -> round_cnt=1, turn=0, busy=0, WAIT_ROLL. A btn_roll returning dice=d -> pos_p1 increments once every 4 cycles, reaching d after 4*d cycles; then turn=1.
REQ-035 P1 reaches 8 and P2 then ends its turn below 8 -> one game_end pulse with game_win=01. A btn_roll afterwards changes nothing.
REQ-036 P1 and P2 both reach 8 in the same round -> game_win=00, game_end pulses once.
REQ-037 After 3 rounds with pos_p1=5 and pos_p2=6 -> game_win=10. With 6/6 -> game_win=00.
REQ-038 A roll of 6 at pos=5 -> pos saturates at 8 after 3 steps, with no step counted beyond 8.
REQ-039 restart during MOVE, and asserted together with game_start, -> IDLE with all outputs 0. rst_n pulsed mid-MOVE -> all outputs at reset values immediately.
